// File: rtl/io_pkg.sv
// Purpose: shared state encoding and default sizing for the I/O port controller.
// Latency: n/a (constants only).
// Backpressure: n/a.
package io_pkg;

    // FSM state encoding
    localparam logic [1:0] IO_IDLE    = 2'd0;
    localparam logic [1:0] IO_RD_WAIT = 2'd1;
    localparam logic [1:0] IO_WR_WAIT = 2'd2;
    localparam logic [1:0] IO_DONE    = 2'd3;

    // Default sizing: 16-bit ports, 8 wait cycles before a transfer is abandoned
    localparam int IO_DATA_W  = 16;
    localparam int IO_TIMEOUT = 8;
    localparam int IO_CNT_W   = 4;

endpackage

// File: rtl/io_timeout_counter.sv
// Purpose: wait-state counter that flags the last allowed cycle of a transfer.
// Latency: tc is combinational from the count; count updates one cycle after en.
// Backpressure: saturates at TIMEOUT-1 and holds there, never wraps.
module io_timeout_counter #(
    parameter int TIMEOUT = 8,
    parameter int CNT_W   = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc = (cnt_q == CNT_W'(TIMEOUT - 1));

    // Next count: clear wins, otherwise step until the terminal count is reached
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !tc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/io_port_controller.sv
// Purpose: runs IN/OUT instructions over a valid/ack port handshake, stalling the pipe meanwhile.
// Latency: 3 cycles request-to-release with an immediate handshake, TIMEOUT+2 worst case.
// Backpressure: stall held while a transfer waits; a silent device is abandoned after TIMEOUT waits.
module io_port_controller
    import io_pkg::*;
#(
    parameter int DATA_W  = IO_DATA_W,
    parameter int TIMEOUT = IO_TIMEOUT,
    parameter int CNT_W   = IO_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              io_en,
    input  logic              io_rd,
    input  logic              io_wr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] port_in,
    input  logic              port_in_valid,
    output logic              port_in_ack,
    output logic [DATA_W-1:0] port_out,
    output logic              port_out_valid,
    input  logic              port_out_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              stall,
    output logic              done,
    output logic              timeout_err,
    output logic              proto_err
);

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] port_out_q, port_out_d;
    logic              port_out_valid_q, port_out_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              to_flag_q, to_flag_d;
    logic              proto_err_q, proto_err_d;
    logic              cnt_clr, cnt_en, cnt_tc;

    io_timeout_counter #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .tc    (cnt_tc)
    );

    // State and data registers; reset mid-transfer simply drops the transfer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= IO_IDLE;
            port_out_q       <= '0;
            port_out_valid_q <= 1'b0;
            rd_data_q        <= '0;
            to_flag_q        <= 1'b0;
            proto_err_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            port_out_q       <= port_out_d;
            port_out_valid_q <= port_out_valid_d;
            rd_data_q        <= rd_data_d;
            to_flag_q        <= to_flag_d;
            proto_err_q      <= proto_err_d;
        end
    end

    // Next state and data; a handshake on the terminal-count cycle still counts as success
    always_comb begin
        state_d          = state_q;
        port_out_d       = port_out_q;
        port_out_valid_d = port_out_valid_q;
        rd_data_d        = rd_data_q;
        to_flag_d        = to_flag_q;
        proto_err_d      = proto_err_q;
        cnt_clr          = 1'b0;
        cnt_en           = 1'b0;
        case (state_q)
            IO_IDLE: begin
                cnt_clr   = 1'b1;
                to_flag_d = 1'b0;
                if (io_en && io_rd) begin
                    // read wins a conflicting request; the write is dropped
                    state_d = IO_RD_WAIT;
                    if (io_wr) begin
                        proto_err_d = 1'b1;
                    end
                end else if (io_en && io_wr) begin
                    port_out_d       = wr_data;
                    port_out_valid_d = 1'b1;
                    state_d          = IO_WR_WAIT;
                end
            end
            IO_RD_WAIT: begin
                if (port_in_valid) begin
                    rd_data_d = port_in;
                    state_d   = IO_DONE;
                end else if (cnt_tc) begin
                    rd_data_d = '0;
                    to_flag_d = 1'b1;
                    state_d   = IO_DONE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            IO_WR_WAIT: begin
                if (port_out_ack) begin
                    port_out_valid_d = 1'b0;
                    state_d          = IO_DONE;
                end else if (cnt_tc) begin
                    port_out_valid_d = 1'b0;
                    to_flag_d        = 1'b1;
                    state_d          = IO_DONE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: begin
                // DONE: the still-present request is not re-sampled
                state_d = IO_IDLE;
            end
        endcase
    end

    // Outputs; stall drops in DONE so the pipeline can move the instruction on
    always_comb begin
        stall       = 1'b0;
        done        = 1'b0;
        timeout_err = 1'b0;
        port_in_ack = 1'b0;
        case (state_q)
            IO_IDLE:    stall = io_en && (io_rd || io_wr);
            IO_RD_WAIT: begin
                stall       = 1'b1;
                port_in_ack = port_in_valid;
            end
            IO_WR_WAIT: stall = 1'b1;
            default: begin
                done        = 1'b1;
                timeout_err = to_flag_q;
            end
        endcase
    end

    assign port_out       = port_out_q;
    assign port_out_valid = port_out_valid_q;
    assign rd_data        = rd_data_q;
    assign proto_err      = proto_err_q;

endmodule

// File: tb/tb_io_port_controller.sv
module tb_io_port_controller;

    localparam int DW = 16;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          io_en, io_rd, io_wr;
    logic [DW-1:0] wr_data, port_in;
    logic          port_in_valid, port_in_ack;
    logic [DW-1:0] port_out;
    logic          port_out_valid, port_out_ack;
    logic [DW-1:0] rd_data;
    logic          stall, done, timeout_err, proto_err;

    io_port_controller #(.DATA_W(DW), .TIMEOUT(TO), .CNT_W(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .io_en          (io_en),
        .io_rd          (io_rd),
        .io_wr          (io_wr),
        .wr_data        (wr_data),
        .port_in        (port_in),
        .port_in_valid  (port_in_valid),
        .port_in_ack    (port_in_ack),
        .port_out       (port_out),
        .port_out_valid (port_out_valid),
        .port_out_ack   (port_out_ack),
        .rd_data        (rd_data),
        .stall          (stall),
        .done           (done),
        .timeout_err    (timeout_err),
        .proto_err      (proto_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int            done_cyc;
        logic [DW-1:0] rd;
        logic [DW-1:0] po;
        logic          to;
        logic          pe;
    } exp_t;

    exp_t q[$];

    // per-cycle expectations set by the stimulus, and the architectural model
    logic          exp_stall = 1'b0, exp_pov = 1'b0, exp_ack = 1'b0;
    bit            mon_on = 1'b0;
    logic [DW-1:0] m_po = '0, m_rd = '0;
    logic          m_pe = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: per-cycle handshake/stall checks, scoreboard pop on every done pulse
    always @(negedge clk) begin
        if (mon_on && reset) begin
            chk("stall", {31'b0, stall}, {31'b0, exp_stall});
            chk("port_out_valid", {31'b0, port_out_valid}, {31'b0, exp_pov});
            chk("port_in_ack", {31'b0, port_in_ack}, {31'b0, exp_ack});
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("done_cycle", cyc, e.done_cyc);
                    chk("rd_data", {16'b0, rd_data}, {16'b0, e.rd});
                    chk("port_out", {16'b0, port_out}, {16'b0, e.po});
                    chk("timeout_err", {31'b0, timeout_err}, {31'b0, e.to});
                    chk("proto_err", {31'b0, proto_err}, {31'b0, e.pe});
                end
            end else begin
                chk("timeout_err_idle", {31'b0, timeout_err}, 32'd0);
                if (q.size() > 0 && cyc > q[0].done_cyc) begin
                    chk("missing_done", 32'd0, 32'd1);
                    void'(q.pop_front());
                end
            end
        end
    end

    // One transfer. kind: 0 read, 1 write, 2 read+write conflict.
    // d = wait cycle (0-based) on which the device handshakes; d >= TO means never in time.
    task automatic do_xfer(input int kind, input logic [DW-1:0] val, input int d);
        bit   ok;
        int   w;
        exp_t e;
        ok = (d < TO);
        w  = ok ? d + 1 : TO;
        @(posedge clk); #1;
        io_en         = 1'b1;
        io_rd         = (kind != 1);
        io_wr         = (kind != 0);
        wr_data       = (kind == 1) ? val : DW'($urandom);
        port_in       = (kind == 1) ? DW'($urandom) : val;
        port_in_valid = 1'($urandom);
        port_out_ack  = 1'($urandom);
        exp_stall     = 1'b1;
        exp_pov       = 1'b0;
        exp_ack       = 1'b0;
        if (kind == 2) m_pe = 1'b1;
        if (kind == 1) m_po = val;
        else           m_rd = ok ? val : '0;
        e.done_cyc = cyc + w + 1;
        e.rd = m_rd;
        e.po = m_po;
        e.to = !ok;
        e.pe = m_pe;
        q.push_back(e);
        for (int k = 0; k < w; k++) begin
            @(posedge clk); #1;
            exp_stall = 1'b1;
            exp_pov   = (kind == 1);
            if (kind == 1) begin
                port_out_ack  = (k == d);
                port_in_valid = 1'($urandom);
                exp_ack       = 1'b0;
            end else begin
                port_in_valid = (k == d);
                port_out_ack  = 1'($urandom);
                exp_ack       = (k == d);
            end
        end
        // DONE cycle: request still held, must not be re-sampled
        @(posedge clk); #1;
        exp_stall     = 1'b0;
        exp_pov       = 1'b0;
        exp_ack       = 1'b0;
        port_in_valid = 1'($urandom);
        port_out_ack  = 1'($urandom);
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        io_en = 1'($urandom);
        if (io_en) begin
            io_rd = 1'b0;
            io_wr = 1'b0;
        end else begin
            io_rd = 1'($urandom);
            io_wr = 1'($urandom);
        end
        port_in_valid = 1'($urandom);
        port_out_ack  = 1'($urandom);
        port_in       = DW'($urandom);
        wr_data       = DW'($urandom);
        exp_stall     = 1'b0;
        exp_pov       = 1'b0;
        exp_ack       = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        io_en = 1'b0; io_rd = 1'b0; io_wr = 1'b0;
        wr_data = '0; port_in = '0; port_in_valid = 1'b0; port_out_ack = 1'b0;
        #12;
        chk("rst_port_out", {16'b0, port_out}, 32'd0);
        chk("rst_rd_data", {16'b0, rd_data}, 32'd0);
        chk("rst_port_out_valid", {31'b0, port_out_valid}, 32'd0);
        chk("rst_port_in_ack", {31'b0, port_in_ack}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_timeout_err", {31'b0, timeout_err}, 32'd0);
        chk("rst_proto_err", {31'b0, proto_err}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        reset  = 1'b1;
        mon_on = 1'b1;
        idle_cycle();

        // directed cases
        do_xfer(0, 16'h1234, 0);          // fast read
        idle_cycle();
        do_xfer(1, 16'hA5A5, 3);          // write, ack after 3 wait cycles
        idle_cycle();
        do_xfer(0, 16'h4321, TO + 1);     // read timeout
        do_xfer(1, 16'h5A5A, TO - 1);     // ack on the terminal-count cycle
        do_xfer(0, 16'h6666, TO - 1);     // read valid on the terminal-count cycle
        do_xfer(1, 16'h7777, TO);         // write timeout
        idle_cycle();
        do_xfer(2, 16'h00FF, 0);          // conflicting request
        idle_cycle();

        // randomized traffic
        for (int i = 0; i < 80; i++) begin
            int gap;
            do_xfer(int'($urandom_range(0, 2)), DW'($urandom), int'($urandom_range(0, TO + 2)));
            gap = int'($urandom_range(0, 2));
            for (int j = 0; j < gap; j++) idle_cycle();
        end
        idle_cycle();
        idle_cycle();
        chk("scoreboard_drained", q.size(), 32'd0);

        // reset in the middle of a write wait
        @(posedge clk); #1;
        io_en = 1'b1; io_rd = 1'b0; io_wr = 1'b1; wr_data = 16'hBEEF;
        port_out_ack = 1'b0; port_in_valid = 1'b0;
        exp_stall = 1'b1; exp_pov = 1'b0; exp_ack = 1'b0;
        @(posedge clk); #1;
        exp_pov = 1'b1;
        @(posedge clk); #3;
        chk("mid_port_out_before", {16'b0, port_out}, 32'h0000BEEF);
        mon_on = 1'b0;
        reset  = 1'b0;
        io_en  = 1'b0;
        #1;
        chk("mid_rst_port_out", {16'b0, port_out}, 32'd0);
        chk("mid_rst_port_out_valid", {31'b0, port_out_valid}, 32'd0);
        chk("mid_rst_stall", {31'b0, stall}, 32'd0);
        chk("mid_rst_proto_err", {31'b0, proto_err}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mid_rst_done", {31'b0, done}, 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        m_po = '0; m_rd = '0; m_pe = 1'b0;
        exp_stall = 1'b0; exp_pov = 1'b0; exp_ack = 1'b0;
        mon_on = 1'b1;
        idle_cycle();
        idle_cycle();
        do_xfer(0, 16'hC0DE, 2);
        idle_cycle();
        idle_cycle();
        chk("final_drained", q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
